rst_seq_ctrl: RTL

- Reset sequencer and controller for the clock/reset resource.
- Qualifies PLL lock, then releases three reset domains in a fixed order (core, then periph, then io). Stage spacing is timed in microseconds by counting pluse_us.
- Re-sequences on PLL lock loss or on a software reset request.
- Sits in the clk_sys domain beside pluse_us_gen; its outputs drive the downstream block resets.

---
 rtl/clk_rst_pkg.sv | 15 +
 rtl/us_tick_cnt.sv | 26 ++
 rtl/rst_seq_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared state encodings for the reset sequencer
package clk_rst_pkg;

   localparam int SEQ_ST_W = 3;

   typedef enum logic [SEQ_ST_W-1:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_STABLE    = 3'd1,
      ST_CORE      = 3'd2,
      ST_PERIPH    = 3'd3,
      ST_RUN       = 3'd4,
      ST_SOFT_HOLD = 3'd5
   } seq_st_e;

endpackage

// File: rtl/us_tick_cnt.sv
// rtl/us_tick_cnt.sv - microsecond pulse counter with terminal-count hit
module us_tick_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             pluse_us,
   input  logic [CNT_W-1:0] target,
   output logic             hit
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk_sys) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (pluse_us) begin
         count <= count + CNT_W'(1);
      end
   end

   // hit fires on the pulse that completes the target, so the owner leaves on that edge
   assign hit = (target == '0) || (pluse_us && (count == target - CNT_W'(1)));

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - PLL-qualified ordered release of core, periph and io resets
module rst_seq_ctrl
   import clk_rst_pkg::*;
#(
   parameter int LOCK_WAIT_US = 100,
   parameter int STAGE_GAP_US = 10,
   parameter int SOFT_HOLD_US = 5,
   parameter int CNT_W        = 16
) (
   input  logic                clk_sys,
   input  logic                rst_n,
   input  logic                pluse_us,
   input  logic                pll_locked,
   input  logic                soft_rst_req,
   output logic                rst_n_core,
   output logic                rst_n_periph,
   output logic                rst_n_io,
   output logic                seq_done,
   output logic [SEQ_ST_W-1:0] seq_state
);

   seq_st_e          state_q;
   seq_st_e          state_d;
   logic             hit;
   logic             cnt_clr;
   logic             counting;
   logic [CNT_W-1:0] target;

   always_comb begin
      target   = '0;
      counting = 1'b1;
      case (state_q)
         ST_STABLE:    target = CNT_W'(LOCK_WAIT_US);
         ST_CORE:      target = CNT_W'(STAGE_GAP_US);
         ST_PERIPH:    target = CNT_W'(STAGE_GAP_US);
         ST_SOFT_HOLD: target = CNT_W'(SOFT_HOLD_US);
         default:      counting = 1'b0;
      endcase
   end

   assign cnt_clr = (state_d != state_q) || !counting;

   us_tick_cnt #(
      .CNT_W (CNT_W)
   ) u_tick (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .pluse_us (pluse_us),
      .target   (target),
      .hit      (hit)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT_LOCK: if (pll_locked)   state_d = ST_STABLE;
         ST_STABLE:    if (hit)          state_d = ST_CORE;
         ST_CORE:      if (hit)          state_d = ST_PERIPH;
         ST_PERIPH:    if (hit)          state_d = ST_RUN;
         ST_RUN:       if (soft_rst_req) state_d = ST_SOFT_HOLD;
         ST_SOFT_HOLD: if (hit)          state_d = ST_STABLE;
         default:                        state_d = ST_WAIT_LOCK;
      endcase
      // lock loss overrides soft requests and counter expiry alike
      if (!pll_locked) begin
         state_d = ST_WAIT_LOCK;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT_LOCK;
         rst_n_core   <= 1'b0;
         rst_n_periph <= 1'b0;
         rst_n_io     <= 1'b0;
         seq_done     <= 1'b0;
         seq_state    <= '0;
      end else begin
         state_q      <= state_d;
         rst_n_core   <= (state_d == ST_CORE) || (state_d == ST_PERIPH) || (state_d == ST_RUN);
         rst_n_periph <= (state_d == ST_PERIPH) || (state_d == ST_RUN);
         rst_n_io     <= (state_d == ST_RUN);
         seq_done     <= (state_d == ST_RUN);
         seq_state    <= state_d;
      end
   end

endmodule
